// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath and its microcode sequencer.
// Optional bus-driver conflict checking is enabled with SAP_BUS_CHECK_EN.
package sap_pkg;

    localparam int SAP_DATA_W = 8;
    localparam int SAP_ADDR_W = 4;

    // Control-word bit positions, shared with the sequencer
    localparam int HLT_B = 15;
    localparam int MI_B  = 14;
    localparam int RI_B  = 13;
    localparam int RO_B  = 12;
    localparam int IO_B  = 11;
    localparam int II_B  = 10;
    localparam int AI_B  = 9;
    localparam int AO_B  = 8;
    localparam int EO_B  = 7;
    localparam int SU_B  = 6;
    localparam int BI_B  = 5;
    localparam int OI_B  = 4;
    localparam int CE_B  = 3;
    localparam int CO_B  = 2;
    localparam int J_B   = 1;
    localparam int FI_B  = 0;

    typedef enum logic [3:0] {
        NOP = 4'h0,
        LDA = 4'h1,
        ADD = 4'h2,
        SUB = 4'h3,
        STA = 4'h4,
        LDI = 4'h5,
        JMP = 4'h6,
        JC  = 4'h7,
        JZ  = 4'h8,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit for the SAP datapath.
// Subtraction is A + ~B + 1, so carry out = 1 means "no borrow".
module sap_alu
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W-1:0] w_bOperand;
    logic [DATA_W:0]   w_sum;

    assign w_bOperand = i_sub ? ~i_b : i_b;
    assign w_sum      = {1'b0, i_a} + {1'b0, w_bOperand} + {{DATA_W{1'b0}}, i_sub};
    assign o_result   = w_sum[DATA_W-1:0];
    assign o_carry    = w_sum[DATA_W];
    assign o_zero     = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// SAP bus datapath: PC, MAR, RAM, IR, A, B, ALU, flags and output register.
// Define SAP_BUS_CHECK_EN to flag edges where more than one bus driver is on.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ctrl_word,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic              flag_c,
    output logic              flag_z,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic              bus_conflict
);

    logic [DATA_W-1:0] r_ram [2**ADDR_W];
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_flagC;
    logic              r_flagZ;
    logic              r_outValid;
    state_e            r_state;

    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_aluResult;
    logic              w_aluCarry;
    logic              w_aluZero;
    logic              w_run;

    // A HLT word suppresses every other bit at its own edge as well
    assign w_run = (r_state == ST_RUN) && !ctrl_word[HLT_B];

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sub    (ctrl_word[SU_B]),
        .o_result (w_aluResult),
        .o_carry  (w_aluCarry),
        .o_zero   (w_aluZero)
    );

    always_comb begin
        w_bus = '0;
        if (ctrl_word[RO_B]) w_bus = w_bus | r_ram[r_mar];
        if (ctrl_word[IO_B]) w_bus = w_bus | {{(DATA_W-4){1'b0}}, r_ir[3:0]};
        if (ctrl_word[AO_B]) w_bus = w_bus | r_a;
        if (ctrl_word[EO_B]) w_bus = w_bus | w_aluResult;
        if (ctrl_word[CO_B]) w_bus = w_bus | {{(DATA_W-ADDR_W){1'b0}}, r_pc};
    end

    // RAM is never reset; the later program-load write takes priority over RI
    always_ff @(posedge clk) begin
        if (w_run && ctrl_word[RI_B]) r_ram[r_mar] <= w_bus;
        if (prog_we) r_ram[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_pc       <= '0;
            r_mar      <= '0;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_out      <= '0;
            r_flagC    <= 1'b0;
            r_flagZ    <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (ctrl_word[HLT_B]) begin
                        r_state <= ST_HALTED;
                    end else begin
                        if (ctrl_word[MI_B]) r_mar <= w_bus[ADDR_W-1:0];
                        if (ctrl_word[II_B]) r_ir  <= w_bus;
                        if (ctrl_word[AI_B]) r_a   <= w_bus;
                        if (ctrl_word[BI_B]) r_b   <= w_bus;
                        if (ctrl_word[OI_B]) begin
                            r_out      <= w_bus;
                            r_outValid <= 1'b1;
                        end
                        if (ctrl_word[FI_B]) begin
                            r_flagC <= w_aluCarry;
                            r_flagZ <= w_aluZero;
                        end
                        if (ctrl_word[J_B])       r_pc <= w_bus[ADDR_W-1:0];
                        else if (ctrl_word[CE_B]) r_pc <= r_pc + 1'b1;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
            endcase
        end
    end

`ifdef SAP_BUS_CHECK_EN
    logic       r_busConflict;
    logic [2:0] w_driverCount;

    assign w_driverCount = {2'b00, ctrl_word[RO_B]} + {2'b00, ctrl_word[IO_B]}
                         + {2'b00, ctrl_word[AO_B]} + {2'b00, ctrl_word[EO_B]}
                         + {2'b00, ctrl_word[CO_B]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busConflict <= 1'b0;
        else if (w_run && (w_driverCount > 3'd1))
            r_busConflict <= 1'b1;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && w_run && (w_driverCount > 3'd1))
            $error("sap_datapath: multiple bus drivers, ctrl_word=0x%04h", ctrl_word);
    end
`endif

    assign bus_conflict = r_busConflict;
`else
    assign bus_conflict = 1'b0;
`endif

    assign opcode    = r_ir[7:4];
    assign flag_c    = r_flagC;
    assign flag_z    = r_flagZ;
    assign out_data  = r_out;
    assign out_valid = r_outValid;
    assign halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: ALU vector table, directed
// fetch/store/jump/halt/reset sequences and a randomized run against a model.
module tb_sap_datapath;

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    logic        clk;
    logic        rst_n;
    logic [15:0] ctrl_word;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        halted;
    logic        bus_conflict;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state, kept as plain integers
    int mRam [16];
    int mPc, mMar, mIr, mA, mB, mOut;
    int mC, mZ, mOutValid, mHalted, mConflict;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       su;
        logic [7:0] r;
        logic       c;
        logic       z;
    } aluVec_t;

    aluVec_t vecs [7];

    sap_datapath dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_word    (ctrl_word),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .opcode       (opcode),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .halted       (halted),
        .bus_conflict (bus_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        mPc = 0; mMar = 0; mIr = 0; mA = 0; mB = 0; mOut = 0;
        mC = 0; mZ = 0; mOutValid = 0; mHalted = 0; mConflict = 0;
    endtask

    task automatic modelStep(input logic [15:0] cw, input logic pwe, input logic [3:0] pa, input logic [7:0] pd);
        int bus, aluR, aluC, drivers;
        mOutValid = 0;
        if (mHalted == 0 && cw[15]) begin
            mHalted = 1;
        end else if (mHalted == 0) begin
            if (cw[6]) begin
                aluR = (mA - mB + 256) % 256;
                aluC = (mA >= mB) ? 1 : 0;
            end else begin
                aluR = (mA + mB) % 256;
                aluC = (mA + mB > 255) ? 1 : 0;
            end
            bus = 0;
            drivers = 0;
            if (cw[12]) begin bus = bus | mRam[mMar]; drivers++; end
            if (cw[11]) begin bus = bus | (mIr % 16); drivers++; end
            if (cw[8])  begin bus = bus | mA;         drivers++; end
            if (cw[7])  begin bus = bus | aluR;       drivers++; end
            if (cw[2])  begin bus = bus | mPc;        drivers++; end
`ifdef SAP_BUS_CHECK_EN
            if (drivers > 1) mConflict = 1;
`endif
            if (cw[13]) mRam[mMar] = bus;
            if (cw[14]) mMar = bus % 16;
            if (cw[10]) mIr = bus;
            if (cw[9])  mA = bus;
            if (cw[5])  mB = bus;
            if (cw[4])  begin mOut = bus; mOutValid = 1; end
            if (cw[0])  begin mC = aluC; mZ = (aluR == 0) ? 1 : 0; end
            if (cw[1])       mPc = bus % 16;
            else if (cw[3])  mPc = (mPc + 1) % 16;
        end
        if (pwe) mRam[pa] = pd;
    endtask

    task automatic compareAll();
        checkOutput("opcode",       16'(opcode),        16'(mIr / 16));
        checkOutput("flag_c",       16'(flag_c),        16'(mC));
        checkOutput("flag_z",       16'(flag_z),        16'(mZ));
        checkOutput("out_data",     16'(out_data),      16'(mOut));
        checkOutput("out_valid",    16'(out_valid),     16'(mOutValid));
        checkOutput("halted",       16'(halted),        16'(mHalted));
        checkOutput("bus_conflict", 16'(bus_conflict),  16'(mConflict));
        checkOutput("reg_a",        16'(dut.r_a),       16'(mA));
        checkOutput("reg_b",        16'(dut.r_b),       16'(mB));
        checkOutput("reg_pc",       16'(dut.r_pc),      16'(mPc));
        checkOutput("reg_mar",      16'(dut.r_mar),     16'(mMar));
        checkOutput("reg_ir",       16'(dut.r_ir),      16'(mIr));
    endtask

    // One clock: drive at the falling edge, commit at the rising edge, check 1ns later
    task automatic applyStimulus(input logic [15:0] cw, input logic pwe = 1'b0,
                                 input logic [3:0] pa = 4'h0, input logic [7:0] pd = 8'h00);
        @(negedge clk);
        ctrl_word = cw;
        prog_we   = pwe;
        prog_addr = pa;
        prog_data = pd;
        modelStep(cw, pwe, pa, pd);
        @(posedge clk);
        #1;
        compareAll();
        ctrl_word = 16'h0000;
        prog_we   = 1'b0;
    endtask

    task automatic loadA(input logic [7:0] v);
        applyStimulus(16'h0000, 1'b1, 4'(mMar), v);
        applyStimulus(C_RO | C_AI);
    endtask

    task automatic loadB(input logic [7:0] v);
        applyStimulus(16'h0000, 1'b1, 4'(mMar), v);
        applyStimulus(C_RO | C_BI);
    endtask

    task automatic loadIr(input logic [7:0] v);
        applyStimulus(16'h0000, 1'b1, 4'(mMar), v);
        applyStimulus(C_RO | C_II);
    endtask

    initial begin
        int aBefore, pcBefore, pick;
        logic [15:0] cw;

        vecs[0] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
        vecs[1] = '{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[6] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};

        rst_n     = 1'b0;
        ctrl_word = 16'h0000;
        prog_we   = 1'b0;
        prog_addr = 4'h0;
        prog_data = 8'h00;
        resetModel();
        #12;
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            applyStimulus(16'h0000, 1'b1, 4'(i), 8'($urandom_range(0, 255)));

        // Fetch of the first instruction
        applyStimulus(16'h0000, 1'b1, 4'h0, 8'h1E);
        applyStimulus(C_MI | C_CO);
        applyStimulus(C_RO | C_II | C_CE);
        checkOutput("fetch_opcode", 16'(opcode), 16'h0001);
        checkOutput("fetch_ir",     16'(dut.r_ir), 16'h001E);
        checkOutput("fetch_pc",     16'(dut.r_pc), 16'h0001);
        checkOutput("fetch_mar",    16'(dut.r_mar), 16'h0000);

        for (int i = 0; i < 7; i++) begin
            loadA(vecs[i].a);
            loadB(vecs[i].b);
            applyStimulus(C_EO | C_AI | C_FI | (vecs[i].su ? C_SU : 16'h0000));
            checkOutput($sformatf("alu%0d_c", i), 16'(flag_c), 16'(vecs[i].c));
            checkOutput($sformatf("alu%0d_z", i), 16'(flag_z), 16'(vecs[i].z));
            applyStimulus(C_AO | C_OI);
            checkOutput($sformatf("alu%0d_r", i), 16'(out_data), 16'(vecs[i].r));
        end

        // Store A to RAM[15], clear A, load it back
        loadA(8'h5A);
        loadIr(8'h4F);
        applyStimulus(C_IO | C_MI);
        checkOutput("sta_mar", 16'(dut.r_mar), 16'h000F);
        applyStimulus(C_AO | C_RI);
        checkOutput("sta_ram", 16'(dut.r_ram[15]), 16'h005A);
        applyStimulus(C_AI);
        checkOutput("clear_a", 16'(dut.r_a), 16'h0000);
        applyStimulus(C_RO | C_AI);
        checkOutput("lda_a", 16'(dut.r_a), 16'h005A);

        // PC jump, wrap and J-over-CE priority
        applyStimulus(C_IO | C_J);
        checkOutput("jmp_pc15", 16'(dut.r_pc), 16'h000F);
        applyStimulus(C_CE);
        checkOutput("pc_wrap", 16'(dut.r_pc), 16'h0000);
        loadIr(8'h07);
        applyStimulus(C_IO | C_J | C_CE);
        checkOutput("j_over_ce", 16'(dut.r_pc), 16'h0007);

`ifdef SAP_BUS_CHECK_EN
        applyStimulus(C_AO | C_CO);
        checkOutput("conflict_set", 16'(bus_conflict), 16'h0001);
        applyStimulus(16'h0000);
        checkOutput("conflict_sticky", 16'(bus_conflict), 16'h0001);
`else
        applyStimulus(C_AO | C_IO | C_AI);
        checkOutput("bus_or", 16'(dut.r_a), 16'h005F);
        checkOutput("conflict_off", 16'(bus_conflict), 16'h0000);
`endif

        // Output register and single-cycle valid pulse
        loadA(8'h2C);
        applyStimulus(C_AO | C_OI);
        checkOutput("out_data", 16'(out_data), 16'h002C);
        checkOutput("out_pulse", 16'(out_valid), 16'h0001);
        applyStimulus(16'h0000);
        checkOutput("out_pulse_end", 16'(out_valid), 16'h0000);
        checkOutput("out_hold", 16'(out_data), 16'h002C);

        // Randomized run with at most one bus driver per word
        for (int n = 0; n < 400; n++) begin
            cw = 16'($urandom_range(0, 65535));
            cw = cw & ~(C_HLT | C_RO | C_IO | C_AO | C_EO | C_CO);
            pick = $urandom_range(0, 5);
            case (pick)
                1: cw = cw | C_RO;
                2: cw = cw | C_IO;
                3: cw = cw | C_AO;
                4: cw = cw | C_EO;
                5: cw = cw | C_CO;
                default: cw = cw;
            endcase
            applyStimulus(cw, 1'($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        end

        // Halt freezes registers, program load still works, reset clears
        loadIr(8'h03);
        aBefore  = mA;
        pcBefore = mPc;
        applyStimulus(C_HLT | C_AI | C_CE | C_IO);
        checkOutput("halt_flag", 16'(halted), 16'h0001);
        checkOutput("halt_a", 16'(dut.r_a), 16'(aBefore));
        checkOutput("halt_pc", 16'(dut.r_pc), 16'(pcBefore));
        applyStimulus(C_RO | C_AI | C_CE | C_OI, 1'b1, 4'h0, 8'h99);
        checkOutput("halted_ai", 16'(dut.r_a), 16'(aBefore));
        checkOutput("halted_valid", 16'(out_valid), 16'h0000);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput("arst_halted", 16'(halted), 16'h0000);
        checkOutput("arst_a", 16'(dut.r_a), 16'h0000);
        checkOutput("arst_pc", 16'(dut.r_pc), 16'h0000);
        checkOutput("arst_out", 16'(out_data), 16'h0000);
        checkOutput("arst_opcode", 16'(opcode), 16'h0000);
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(C_RO | C_OI);
        checkOutput("ram_after_halt", 16'(out_data), 16'h0099);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
